// File: rtl/stop_it_pkg.sv
// Shared types and constants for the Stop It round sequencer.
package stop_it_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    RUNNING = 3'd2,
    WON     = 3'd3,
    LOST    = 3'd4
  } state_e;

  localparam int COUNT_W = 5;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 5'h1F;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stop_it_edge_det.sv
// Rising-edge detector for an already-synchronised button level.
module stop_it_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level_i;
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/stop_it_game_ctrl.sv
// Stop It round sequencer: pre-delay, countdown, win/lose display and win streak.
// Optional macro STOP_IT_FLASH_EN makes flash_o blink instead of lighting steadily.
module stop_it_game_ctrl
  import stop_it_pkg::*;
#(
  parameter logic [COUNT_W-1:0] TARGET       = 5'd10,
  parameter int                 DELAY_TICKS  = 8,
  parameter int                 RESULT_TICKS = 16,
  parameter int                 SCORE_W      = 4
) (
  input  logic               clk_4_i,
  input  logic               rst_ni,
  input  logic               go_i,
  input  logic               stop_i,
  input  logic [COUNT_W-1:0] count_i,
  output logic               counter_en_o,
  output logic               counter_clr_no,
  output state_e             state_o,
  output logic               win_o,
  output logic               lose_o,
  output logic [SCORE_W-1:0] streak_o,
  output logic               flash_o
);

  localparam int TIMER_W = $clog2(maxInt(DELAY_TICKS, RESULT_TICKS) + 1);
  localparam logic [TIMER_W-1:0] DELAY_LOAD  = TIMER_W'(DELAY_TICKS);
  localparam logic [TIMER_W-1:0] RESULT_LOAD = TIMER_W'(RESULT_TICKS);
  localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [SCORE_W-1:0]   streak_q, streak_d;
  logic                 goPulse, stopPulse;

  stop_it_edge_det u_goEdge (
    .clk     (clk_4_i),
    .rst_n   (rst_ni),
    .level_i (go_i),
    .pulse_o (goPulse)
  );

  stop_it_edge_det u_stopEdge (
    .clk     (clk_4_i),
    .rst_n   (rst_ni),
    .level_i (stop_i),
    .pulse_o (stopPulse)
  );

  always_ff @(posedge clk_4_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      streak_q <= streak_d;
    end
  end

  // The stop edge also gates the enable so the counter freezes on the value the player hit.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    streak_d       = streak_q;
    counter_en_o   = 1'b0;
    counter_clr_no = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (goPulse) begin
          state_d = WAIT;
          timer_d = DELAY_LOAD;
        end
      end
      WAIT: begin
        if (stopPulse) begin
          state_d  = LOST;
          timer_d  = RESULT_LOAD;
          streak_d = '0;
        end else if (timer_q == TIMER_ONE) begin
          state_d = RUNNING;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      RUNNING: begin
        counter_clr_no = 1'b1;
        counter_en_o   = (count_i != '0) && !stopPulse;
        if (stopPulse) begin
          timer_d = RESULT_LOAD;
          if (count_i == TARGET) begin
            state_d = WON;
            if (streak_q != {SCORE_W{1'b1}}) streak_d = streak_q + 1'b1;
          end else begin
            state_d  = LOST;
            streak_d = '0;
          end
        end else if (count_i == '0) begin
          state_d  = LOST;
          timer_d  = RESULT_LOAD;
          streak_d = '0;
        end
      end
      WON, LOST: begin
        counter_clr_no = 1'b1;
        if (goPulse) begin
          state_d = WAIT;
          timer_d = DELAY_LOAD;
        end else if (timer_q == TIMER_ONE) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign state_o  = state_q;
  assign win_o    = (state_q == WON);
  assign lose_o   = (state_q == LOST);
  assign streak_o = streak_q;

`ifdef STOP_IT_FLASH_EN
  logic flash_q, flash_d;
  logic blinkDiv_q, blinkDiv_d;

  // WON blinks at half the clock rate, LOST at a quarter; both start lit on entry.
  always_comb begin
    flash_d    = 1'b0;
    blinkDiv_d = 1'b0;
    if (state_d == WON) begin
      flash_d = (state_q != WON) ? 1'b1 : ~flash_q;
    end else if (state_d == LOST) begin
      if (state_q != LOST) begin
        flash_d = 1'b1;
      end else begin
        blinkDiv_d = ~blinkDiv_q;
        flash_d    = blinkDiv_q ? ~flash_q : flash_q;
      end
    end
  end

  always_ff @(posedge clk_4_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flash_q    <= 1'b0;
      blinkDiv_q <= 1'b0;
    end else begin
      flash_q    <= flash_d;
      blinkDiv_q <= blinkDiv_d;
    end
  end

  assign flash_o = flash_q;
`else
  assign flash_o = win_o | lose_o;
`endif

endmodule

// File: tb/tb_stop_it_game_ctrl.sv
// Self-checking bench for stop_it_game_ctrl with an attached 5-bit down-counter and a round-level reference model.
module tb_stop_it_game_ctrl;
  import stop_it_pkg::*;

  localparam int DELAY  = 8;
  localparam int RESULT = 16;
  localparam int TGT    = 10;
  localparam int SMAX   = 15;

  logic       clk;
  logic       rstN;
  logic       go;
  logic       stop;
  logic [4:0] count;
  logic       en;
  logic       clrN;
  state_e     state;
  logic       win;
  logic       lose;
  logic [3:0] streak;
  logic       flash;

  int checks   = 0;
  int failures = 0;

  // Reference model of one game, tracked in plain integers.
  state_e mState;
  int     mTimer;
  int     mStreak;
  int     mCount;
  int     mInState;
  logic   mGoPrev;
  logic   mStopPrev;

  stop_it_game_ctrl dut (
    .clk_4_i        (clk),
    .rst_ni         (rstN),
    .go_i           (go),
    .stop_i         (stop),
    .count_i        (count),
    .counter_en_o   (en),
    .counter_clr_no (clrN),
    .state_o        (state),
    .win_o          (win),
    .lose_o         (lose),
    .streak_o       (streak),
    .flash_o        (flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The game counter the controller drives: clear loads 31, enable decrements.
  always @(posedge clk or negedge rstN) begin
    if (!rstN)      count <= 5'd31;
    else if (!clrN) count <= 5'd31;
    else if (en)    count <= count - 5'd1;
  end

  function automatic logic expFlash();
`ifdef STOP_IT_FLASH_EN
    if (mState == WON)  return (mInState % 2) == 0;
    if (mState == LOST) return ((mInState / 2) % 2) == 0;
    return 1'b0;
`else
    return (mState == WON) || (mState == LOST);
`endif
  endfunction

  task automatic modelReset();
    mState    = IDLE;
    mTimer    = 0;
    mStreak   = 0;
    mCount    = 31;
    mInState  = 0;
    mGoPrev   = 1'b0;
    mStopPrev = 1'b0;
  endtask

  // Drive button levels for one cycle and advance the model across the same edge.
  task automatic applyStimulus(input logic goL, input logic stopL);
    bit     goP, stopP, running, showing;
    state_e nState;
    int     nTimer, nStreak, nCount;
    @(negedge clk);
    go   = goL;
    stop = stopL;
    goP     = goL && !mGoPrev;
    stopP   = stopL && !mStopPrev;
    running = (mState == RUNNING);
    showing = running || (mState == WON) || (mState == LOST);
    if (!showing)                               nCount = 31;
    else if (running && mCount > 0 && !stopP)   nCount = mCount - 1;
    else                                        nCount = mCount;
    nState  = mState;
    nTimer  = (mTimer > 0) ? mTimer - 1 : 0;
    nStreak = mStreak;
    case (mState)
      IDLE: if (goP) begin nState = WAIT; nTimer = DELAY; end
      WAIT: begin
        if (stopP) begin nState = LOST; nTimer = RESULT; nStreak = 0; end
        else if (mTimer == 1) nState = RUNNING;
      end
      RUNNING: begin
        if (stopP && mCount == TGT) begin
          nState = WON; nTimer = RESULT; nStreak = (mStreak < SMAX) ? mStreak + 1 : SMAX;
        end else if (stopP || mCount == 0) begin
          nState = LOST; nTimer = RESULT; nStreak = 0;
        end
      end
      default: begin
        if (goP) begin nState = WAIT; nTimer = DELAY; end
        else if (mTimer == 1) nState = IDLE;
      end
    endcase
    @(posedge clk);
    #1;
    mInState  = (nState != mState) ? 0 : mInState + 1;
    mState    = nState;
    mTimer    = nTimer;
    mStreak   = nStreak;
    mCount    = nCount;
    mGoPrev   = goL;
    mStopPrev = stopL;
  endtask

  task automatic runToCount(input int val);
    for (int i = 0; i < 40 && mCount != val; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic startRound();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < DELAY; i++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rstN = 1'b0; go = 1'b0; stop = 1'b0;
    modelReset();
    #3;
    checks++;
    if (state !== IDLE || en !== 1'b0 || clrN !== 1'b0 || win !== 1'b0 || lose !== 1'b0 ||
        flash !== 1'b0 || streak !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset: state=%0d en=%b clrN=%b win=%b lose=%b flash=%b streak=%0d, want 0 0 0 0 0 0 0",
               state, en, clrN, win, lose, flash, streak);
    end
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_round_timing();
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < DELAY; i++) begin
      checks++;
      if (state !== WAIT || clrN !== 1'b0 || en !== 1'b0) begin
        failures++;
        $display("[TB] FAIL wait_cycle%0d: state=%0d clrN=%b en=%b, want WAIT 0 0", i, state, clrN, en);
      end
      if (i < DELAY - 1) applyStimulus(1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0);
    checks++;
    if (state !== RUNNING || count !== 5'd31 || en !== 1'b1 || clrN !== 1'b1) begin
      failures++;
      $display("[TB] FAIL enter_running: state=%0d count=%0d en=%b clrN=%b, want RUNNING 31 1 1", state, count, en, clrN);
    end
    applyStimulus(1'b0, 1'b0);
    checks++;
    if (count !== 5'd30) begin
      failures++;
      $display("[TB] FAIL first_decrement: count=%0d want 30", count);
    end
  endtask

  task automatic test_win();
    runToCount(TGT);
    applyStimulus(1'b0, 1'b1);
    checks++;
    if (state !== WON || win !== 1'b1 || lose !== 1'b0 || streak !== 4'd1) begin
      failures++;
      $display("[TB] FAIL win_entry: state=%0d win=%b lose=%b streak=%0d, want WON 1 0 1", state, win, lose, streak);
    end
    for (int i = 0; i < RESULT; i++) begin
      logic wantFlash;
`ifdef STOP_IT_FLASH_EN
      wantFlash = (i % 2) == 0;
`else
      wantFlash = 1'b1;
`endif
      checks++;
      if (state !== WON || count !== 5'd10 || en !== 1'b0 || flash !== wantFlash) begin
        failures++;
        $display("[TB] FAIL won_hold%0d: state=%0d count=%0d en=%b flash=%b, want WON 10 0 %b",
                 i, state, count, en, flash, wantFlash);
      end
      applyStimulus(1'b0, 1'b1);
    end
    checks++;
    if (state !== IDLE || win !== 1'b0 || flash !== 1'b0) begin
      failures++;
      $display("[TB] FAIL won_to_idle: state=%0d win=%b flash=%b, want IDLE 0 0", state, win, flash);
    end
  endtask

  task automatic test_lose();
    bit sawEn;
    startRound();
    runToCount(TGT + 1);
    applyStimulus(1'b0, 1'b1);
    checks++;
    if (state !== LOST || lose !== 1'b1 || streak !== 4'd0 || count !== 5'd11) begin
      failures++;
      $display("[TB] FAIL lose_at11: state=%0d lose=%b streak=%0d count=%0d, want LOST 1 0 11", state, lose, streak, count);
    end
    for (int i = 0; i < 6; i++) begin
      logic wantFlash;
`ifdef STOP_IT_FLASH_EN
      wantFlash = ((i / 2) % 2) == 0;
`else
      wantFlash = 1'b1;
`endif
      checks++;
      if (flash !== wantFlash) begin
        failures++;
        $display("[TB] FAIL lost_flash%0d: flash=%b want %b", i, flash, wantFlash);
      end
      applyStimulus(1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0);
    sawEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (en === 1'b1) sawEn = 1'b1;
      applyStimulus(1'b0, 1'b0);
    end
    if (en === 1'b1) sawEn = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checks++;
    if (state !== LOST || sawEn || en !== 1'b0 || count !== 5'd31) begin
      failures++;
      $display("[TB] FAIL false_start: state=%0d sawEn=%b count=%0d, want LOST 0 31", state, sawEn, count);
    end
  endtask

  task automatic test_timeout();
    startRound();
    for (int i = 0; i < 40 && count !== 5'd0; i++) begin
      checks++;
      if (state !== RUNNING || en !== 1'b1) begin
        failures++;
        $display("[TB] FAIL countdown_en: state=%0d en=%b count=%0d, want RUNNING 1", state, en, count);
      end
      applyStimulus(1'b0, 1'b0);
    end
    checks++;
    if (state !== RUNNING || count !== 5'd0 || en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL count_zero: state=%0d count=%0d en=%b, want RUNNING 0 0", state, count, en);
    end
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checks++;
    if (state !== LOST || count !== 5'd0 || lose !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_lost: state=%0d count=%0d lose=%b, want LOST 0 1", state, count, lose);
    end
  endtask

  task automatic test_streak_saturate();
    for (int k = 1; k <= 16; k++) begin
      startRound();
      runToCount(TGT);
      applyStimulus(1'b0, 1'b1);
      checks++;
      if (state !== WON || int'(streak) != ((k < SMAX) ? k : SMAX)) begin
        failures++;
        $display("[TB] FAIL streak_win%0d: state=%0d streak=%0d, want WON %0d", k, state, streak, (k < SMAX) ? k : SMAX);
      end
    end
  endtask

  task automatic test_go_held();
    int     entries;
    state_e prevState;
    applyStimulus(1'b0, 1'b0);
    entries   = 0;
    prevState = state;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0);
      if (state == WAIT && prevState != WAIT) entries++;
      prevState = state;
    end
    checks++;
    if (entries != 1 || state !== mState) begin
      failures++;
      $display("[TB] FAIL go_held: rounds=%0d state=%0d, want 1 %0d", entries, state, mState);
    end
  endtask

  task automatic test_random();
    logic goL, stopL;
    goL = 1'b0; stopL = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) goL = ~goL;
      if ($urandom_range(0, 5) == 0) stopL = ~stopL;
      applyStimulus(goL, stopL);
      checks++;
      if (state !== mState || int'(count) != mCount || int'(streak) != mStreak ||
          en !== (mState == RUNNING && mCount != 0) ||
          clrN !== (mState == RUNNING || mState == WON || mState == LOST) ||
          win !== (mState == WON) || lose !== (mState == LOST) || flash !== expFlash()) begin
        failures++;
        $display("[TB] FAIL random%0d: state=%0d count=%0d streak=%0d en=%b clrN=%b flash=%b, want %0d %0d %0d flash=%b",
                 i, state, count, streak, en, clrN, flash, mState, mCount, mStreak, expFlash());
      end
    end
  endtask

  task automatic test_async_reset();
    startRound();
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if (state !== IDLE || en !== 1'b0 || clrN !== 1'b0 || streak !== 4'd0) begin
      failures++;
      $display("[TB] FAIL async_reset: state=%0d en=%b clrN=%b streak=%0d, want IDLE 0 0 0", state, en, clrN, streak);
    end
    modelReset();
    go = 1'b0; stop = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_round_timing();
    test_win();
    test_lose();
    test_timeout();
    test_streak_saturate();
    test_go_held();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
